// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the multi-cycle CPU sequencer:
//   - state_e  : sequencer state encoding
//   - OP_*     : recognised major opcodes (instr[6:0])
//   - ALUOP_*  : ALUOp encodings driven to ALU_Control
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    PAUSE  = 3'd5,
    HALT   = 3'd6
  } state_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [1:0] ALUOP_R = 2'b10;
  localparam logic [1:0] ALUOP_I = 2'b00;

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational opcode decoder; drop-in candidate for the existing
// Control block.
// Ports:
//   opcode_i  [6:0] in   major opcode (instr[6:0])
//   alu_op_o  [1:0] out  ALUOp for ALU_Control
//   alu_src_o       out  0 = RS2data, 1 = sign-extended immediate
//   wr_o            out  register-file write required
//   legal_o         out  opcode is supported
// -----------------------------------------------------------------------------
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [1:0] alu_op_o,
  output logic       alu_src_o,
  output logic       wr_o,
  output logic       legal_o
);

  always_comb begin
    alu_op_o  = '0;
    alu_src_o = 1'b0;
    wr_o      = 1'b0;
    legal_o   = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        alu_op_o  = ALUOP_R;
        alu_src_o = 1'b0;
        wr_o      = 1'b1;
        legal_o   = 1'b1;
      end
      OP_ITYPE: begin
        alu_op_o  = ALUOP_I;
        alu_src_o = 1'b1;
        wr_o      = 1'b1;
        legal_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle sequencer for the CPU datapath. Steps each instruction through
// FETCH -> DECODE -> EXEC -> WB and issues the IR/PC/register-file strobes,
// ALUOp and ALUSrc. Supports a handshaked instruction memory, single-step
// debug (PAUSE), halt on an all-zero instruction, illegal-opcode trap and a
// fetch timeout trap.
// Parameters:
//   CNT_W      width of the saturating retired-instruction counter
//   FETCH_TMO  FETCH cycles without imem_ack_i before the timeout trap (>= 1)
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous reset, active low
//   start_i      in   run enable (level)
//   step_mode_i  in   pause after every retired instruction
//   step_i       in   single-cycle pulse releasing PAUSE
//   imem_req_o   out  fetch request
//   imem_ack_i   in   instr_i valid this cycle
//   instr_i      in   instruction word
//   ir_we_o      out  instruction-register load strobe
//   pc_we_o      out  PC <= PC+4 strobe
//   reg_we_o     out  register-file write enable
//   alu_src_o    out  0 = RS2data, 1 = immediate
//   alu_op_o     out  ALUOp
//   busy_o       out  not in IDLE, PAUSE or HALT
//   halted_o     out  sticky halt
//   illegal_o    out  sticky illegal-opcode trap
//   timeout_o    out  sticky fetch-timeout trap
//   retired_o    out  retired-instruction count (saturating)
// All outputs are decoded from registered state/fields only.
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int FETCH_TMO = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_mode_i,
  input  logic             step_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      instr_i,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             reg_we_o,
  output logic             alu_src_o,
  output logic [1:0]       alu_op_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int               TMO_W    = $clog2(FETCH_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TMO - 1);

  state_e             state_q,   state_d;
  logic [TMO_W-1:0]   tmo_q,     tmo_d;
  logic               halted_q,  halted_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  // Fields captured at the fetch handshake; only consumed in DECODE..WB,
  // so they need no reset.
  logic [6:0]         opcode_q;
  logic               zero_q;

  logic [1:0]         dec_alu_op;
  logic               dec_alu_src;
  logic               dec_wr;
  logic               dec_legal;
  logic               in_op;

  ctrl_decode u_decode (
    .opcode_i  (opcode_q),
    .alu_op_o  (dec_alu_op),
    .alu_src_o (dec_alu_src),
    .wr_o      (dec_wr),
    .legal_o   (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = FETCH;
      end
      FETCH: begin
        // An ack arriving in the limit cycle still completes the fetch.
        if (imem_ack_i) begin
          state_d = DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = HALT;
          timeout_d = 1'b1;
          halted_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DECODE: begin
        // All-zero word is a clean stop, distinct from an unknown opcode.
        if (zero_q) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (!dec_legal) begin
          state_d   = HALT;
          illegal_d = 1'b1;
          halted_d  = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = WB;
      end
      WB: begin
        if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
        if (!start_i)         state_d = IDLE;
        else if (step_mode_i) state_d = PAUSE;
        else                  state_d = FETCH;
      end
      PAUSE: begin
        if (!start_i)    state_d = IDLE;
        else if (step_i) state_d = FETCH;
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == FETCH && imem_ack_i) begin
      opcode_q <= instr_i[6:0];
      zero_q   <= (instr_i == 32'h0);
    end
  end

  // Decode-phase window during which ALUOp/ALUSrc are presented.
  assign in_op = (state_q == DECODE) || (state_q == EXEC) || (state_q == WB);

  assign imem_req_o = (state_q == FETCH);
  // DECODE is only ever entered through a fetch handshake, so this is a
  // one-cycle strobe immediately following the accepted ack.
  assign ir_we_o    = (state_q == DECODE);
  assign pc_we_o    = (state_q == WB);
  assign reg_we_o   = (state_q == WB) && dec_wr;
  assign alu_op_o   = in_op ? dec_alu_op  : 2'b00;
  assign alu_src_o  = in_op ? dec_alu_src : 1'b0;
  assign busy_o     = !((state_q == IDLE) || (state_q == PAUSE) || (state_q == HALT));
  assign halted_o   = halted_q;
  assign illegal_o  = illegal_q;
  assign timeout_o  = timeout_q;
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl (CNT_W=2, FETCH_TMO=8). Expected WB
// strobes are queued when each instruction is handed to the DUT and checked
// when pc_we_o appears.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CNT_W     = 2;
  localparam int FETCH_TMO = 8;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_ADDI = 32'h00700293;
  localparam logic [31:0] I_BR   = 32'h00000063;
  localparam logic [31:0] I_ZERO = 32'h00000000;

  typedef struct packed {
    logic       reg_we;
    logic [1:0] alu_op;
    logic       alu_src;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i = 1'b0;
  logic             step_mode_i = 1'b0;
  logic             step_i = 1'b0;
  logic             imem_req_o;
  logic             imem_ack_i = 1'b0;
  logic [31:0]      instr_i = '0;
  logic             ir_we_o;
  logic             pc_we_o;
  logic             reg_we_o;
  logic             alu_src_o;
  logic [1:0]       alu_op_o;
  logic             busy_o;
  logic             halted_o;
  logic             illegal_o;
  logic             timeout_o;
  logic [CNT_W-1:0] retired_o;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   wb_cyc = 0;
  int   wb_cnt = 0;
  int   regwe_cnt = 0;
  int   req_cnt = 0;
  exp_t expq[$];

  exp_t E_R = '{reg_we: 1'b1, alu_op: 2'b10, alu_src: 1'b0};
  exp_t E_I = '{reg_we: 1'b1, alu_op: 2'b00, alu_src: 1'b1};
  exp_t E_N = '{reg_we: 1'b0, alu_op: 2'b00, alu_src: 1'b0};

  multicycle_ctrl #(.CNT_W(CNT_W), .FETCH_TMO(FETCH_TMO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .step_mode_i (step_mode_i),
    .step_i      (step_i),
    .imem_req_o  (imem_req_o),
    .imem_ack_i  (imem_ack_i),
    .instr_i     (instr_i),
    .ir_we_o     (ir_we_o),
    .pc_we_o     (pc_we_o),
    .reg_we_o    (reg_we_o),
    .alu_src_o   (alu_src_o),
    .alu_op_o    (alu_op_o),
    .busy_o      (busy_o),
    .halted_o    (halted_o),
    .illegal_o   (illegal_o),
    .timeout_o   (timeout_o),
    .retired_o   (retired_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every WB must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (imem_req_o) req_cnt++;
    if (reg_we_o)   regwe_cnt++;
    if (pc_we_o) begin
      wb_cnt++;
      wb_cyc = cyc;
      chk("wb_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("wb_reg_we",  32'(reg_we_o),  32'(e.reg_we));
        chk("wb_alu_op",  32'(alu_op_o),  32'(e.alu_op));
        chk("wb_alu_src", 32'(alu_src_o), 32'(e.alu_src));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(imem_req_o), 32'd1);
  endtask

  // Waits for a request, withholds ack for 'stall' cycles, then delivers w.
  // Returns at the negedge of the DECODE cycle.
  task automatic serve(input logic [31:0] w, input int stall, input logic push, input exp_t e);
    wait_req("serve");
    repeat (stall) tick();
    imem_ack_i = 1'b1;
    instr_i    = w;
    if (push) expq.push_back(e);
    tick();
    imem_ack_i = 1'b0;
    instr_i    = '0;
  endtask

  initial begin
    int w0, r0, rw0, start_cyc;
    int ret_model;

    // Reset state and R-type run ending on an all-zero word.
    rst_i = 1'b0;
    tick(); tick();
    chk("rst_busy",    32'(busy_o),    32'd0);
    chk("rst_req",     32'(imem_req_o),32'd0);
    chk("rst_pc_we",   32'(pc_we_o),   32'd0);
    chk("rst_reg_we",  32'(reg_we_o),  32'd0);
    chk("rst_ir_we",   32'(ir_we_o),   32'd0);
    chk("rst_alu_op",  32'(alu_op_o),  32'd0);
    chk("rst_halted",  32'(halted_o),  32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_retired", 32'(retired_o), 32'd0);
    rst_i = 1'b1;
    start_i = 1'b1;
    start_cyc = cyc;
    serve(I_ADD, 0, 1'b1, E_R);
    chk("r_dec_ir_we",   32'(ir_we_o),   32'd1);
    chk("r_dec_alu_op",  32'(alu_op_o),  32'd2);
    chk("r_dec_alu_src", 32'(alu_src_o), 32'd0);
    chk("r_dec_busy",    32'(busy_o),    32'd1);
    tick(); tick(); tick();
    chk("r_latency", 32'(wb_cyc - start_cyc), 32'd4);
    serve(I_ZERO, 0, 1'b0, E_N);
    tick();
    chk("zero_halted",  32'(halted_o),  32'd1);
    chk("zero_illegal", 32'(illegal_o), 32'd0);
    chk("zero_timeout", 32'(timeout_o), 32'd0);
    chk("zero_retired", 32'(retired_o), 32'd1);
    chk("zero_busy",    32'(busy_o),    32'd0);
    chk("zero_wb_cnt",  32'(wb_cnt),    32'd1);
    chk("zero_regwe",   32'(regwe_cnt), 32'd1);

    // I-type; start_i dropped mid-instruction still completes WB.
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    rw0 = regwe_cnt;
    serve(I_ADDI, 0, 1'b1, E_I);
    chk("i_dec_src", 32'(alu_src_o), 32'd1);
    chk("i_dec_op",  32'(alu_op_o),  32'd0);
    tick();
    chk("i_ex_src", 32'(alu_src_o), 32'd1);
    chk("i_ex_op",  32'(alu_op_o),  32'd0);
    start_i = 1'b0;
    tick();
    chk("i_wb_src", 32'(alu_src_o), 32'd1);
    tick();
    chk("i_idle_src",    32'(alu_src_o), 32'd0);
    chk("i_idle_busy",   32'(busy_o),    32'd0);
    chk("i_idle_req",    32'(imem_req_o),32'd0);
    chk("i_idle_halted", 32'(halted_o),  32'd0);
    chk("i_retired",     32'(retired_o), 32'd1);
    chk("i_regwe_once",  32'(regwe_cnt - rw0), 32'd1);

    // Illegal opcode.
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    start_i = 1'b1;
    w0 = wb_cnt;
    serve(I_BR, 0, 1'b0, E_N);
    tick();
    chk("ill_illegal", 32'(illegal_o), 32'd1);
    chk("ill_halted",  32'(halted_o),  32'd1);
    chk("ill_reg_we",  32'(reg_we_o),  32'd0);
    tick(); tick();
    chk("ill_no_wb",   32'(wb_cnt - w0), 32'd0);
    chk("ill_retired", 32'(retired_o),   32'd0);

    // Fetch stall of 3 cycles, no timeout.
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    r0 = req_cnt;
    serve(I_ADD, 3, 1'b1, E_R);
    chk("stall_req_cycles", 32'(req_cnt - r0), 32'd4);
    chk("stall_timeout",    32'(timeout_o),    32'd0);
    start_i = 1'b0;
    tick(); tick(); tick();
    chk("stall_timeout2", 32'(timeout_o), 32'd0);
    chk("stall_retired",  32'(retired_o), 32'd1);
    chk("stall_halted",   32'(halted_o),  32'd0);

    // Fetch timeout, then HALT ignores start/step/ack.
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    start_i = 1'b1;
    tick();
    repeat (FETCH_TMO - 1) tick();
    chk("tmo_last_req",  32'(imem_req_o), 32'd1);
    chk("tmo_not_yet",   32'(timeout_o),  32'd0);
    tick();
    chk("tmo_timeout",   32'(timeout_o),  32'd1);
    chk("tmo_halted",    32'(halted_o),   32'd1);
    chk("tmo_req_off",   32'(imem_req_o), 32'd0);
    chk("tmo_illegal",   32'(illegal_o),  32'd0);
    start_i = 1'b0; tick();
    start_i = 1'b1; tick();
    step_i = 1'b1;  tick();
    step_i = 1'b0;
    imem_ack_i = 1'b1; instr_i = I_ADD;
    tick(); tick();
    imem_ack_i = 1'b0; instr_i = '0;
    chk("halt_req",     32'(imem_req_o), 32'd0);
    chk("halt_busy",    32'(busy_o),     32'd0);
    chk("halt_sticky",  32'(halted_o),   32'd1);
    chk("halt_tmo",     32'(timeout_o),  32'd1);
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    chk("tmo_clr",      32'(timeout_o),  32'd0);
    chk("halt_clr",     32'(halted_o),   32'd0);

    // Single-step mode.
    start_i = 1'b0; tick();
    step_mode_i = 1'b1;
    start_i = 1'b1;
    serve(I_ADD, 0, 1'b1, E_R);
    tick(); tick(); tick();
    chk("pause_busy", 32'(busy_o),     32'd0);
    chk("pause_req",  32'(imem_req_o), 32'd0);
    tick();
    chk("pause_hold", 32'(imem_req_o), 32'd0);
    step_i = 1'b1; tick(); step_i = 1'b0;
    chk("step_fetch", 32'(imem_req_o), 32'd1);
    chk("step_busy",  32'(busy_o),     32'd1);
    serve(I_ADD, 0, 1'b1, E_R);
    tick(); tick(); tick();
    chk("pause2_busy",    32'(busy_o),    32'd0);
    chk("pause2_retired", 32'(retired_o), 32'd2);
    start_i = 1'b0; step_i = 1'b1; tick(); step_i = 1'b0;
    chk("pause_idle_req", 32'(imem_req_o), 32'd0);
    start_i = 1'b1; step_mode_i = 1'b0; tick();
    chk("idle_restart",   32'(imem_req_o), 32'd1);
    serve(I_ZERO, 0, 1'b0, E_N);
    tick();
    chk("step_end_halt",  32'(halted_o),  32'd1);

    // Reset in the middle of WB.
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    serve(I_ADD, 0, 1'b1, E_R);
    tick(); tick();
    serve(I_ADD, 0, 1'b1, E_R);
    tick(); tick();
    chk("mid_wb_pc_we",   32'(pc_we_o),   32'd1);
    chk("mid_wb_retired", 32'(retired_o), 32'd1);
    rst_i = 1'b0;
    tick();
    chk("mid_rst_retired", 32'(retired_o), 32'd0);
    chk("mid_rst_pc_we",   32'(pc_we_o),   32'd0);
    chk("mid_rst_busy",    32'(busy_o),    32'd0);
    w0 = wb_cnt;
    rst_i = 1'b1; start_i = 1'b0;
    tick(); tick();
    chk("mid_rst_no_wb",   32'(wb_cnt - w0), 32'd0);

    // Saturation of the 2-bit retired counter.
    start_i = 1'b1;
    ret_model = 0;
    for (int i = 0; i < 5; i++) begin
      serve(I_ADD, 0, 1'b1, E_R);
      chk("sat_retired", 32'(retired_o), 32'(ret_model));
      if (ret_model < 3) ret_model++;
    end
    tick(); tick();
    serve(I_ZERO, 0, 1'b0, E_N);
    tick();
    chk("sat_final",  32'(retired_o), 32'd3);
    chk("sat_halted", 32'(halted_o),  32'd1);
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
